// File: rtl/taghreed_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor tile.
// State encoding and counter sizing live here.
package taghreed_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 7;
  localparam int CNT_W     = $clog2(WIDTH_MAX + 1);

endpackage

// File: rtl/taghreed_half_subtractor.sv
// Combinational half subtractor: d = x - y, bo = borrow.
// Two of these plus an OR form one full-subtractor bit cell.
module taghreed_half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/tt_um_taghreed_eialsalman_serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, LSB first.
// Optional macro SUB_SAT_EN clamps the difference to 0 on borrow.
module tt_um_taghreed_eialsalman_serial_subtractor
  import taghreed_sub_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   diff_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   diff_nx;
  logic [WIDTH-1:0]   res_nx;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic               bout_q;
  logic               done_q;
  logic               start_q;
  logic               start_ev;
  logic               last;
  logic               d1;
  logic               bo1;
  logic               d_bit;
  logic               bo2;
  logic               borrow_nx;
  logic [WIDTH_MAX-1:0] res_ext;
  logic               unused_ok;

  taghreed_half_subtractor u_hs0 (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .d  (d1),
    .bo (bo1)
  );

  taghreed_half_subtractor u_hs1 (
    .x  (d1),
    .y  (borrow),
    .d  (d_bit),
    .bo (bo2)
  );

  assign borrow_nx = bo1 | bo2;
  assign start_ev  = ui_in[7] & ~start_q;
  assign last      = (cnt == CNT_W'(WIDTH - 1));

  // Next diff word and the value committed on completion
  always_comb begin
    diff_nx = diff_q >> 1;
    diff_nx[WIDTH-1] = d_bit;
    res_nx = diff_nx;
`ifdef SUB_SAT_EN
    if (borrow_nx) res_nx = '0;
`endif
    res_ext = '0;
    res_ext[WIDTH-1:0] = res_q;
  end

  // FSM, operand/diff shift registers and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      res_q   <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= ui_in[7];
      unique case (state)
        IDLE, DONE: begin
          if (start_ev) begin
            a_q    <= ui_in[WIDTH-1:0];
            b_q    <= uio_in[WIDTH-1:0];
            diff_q <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            done_q <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_nx;
          borrow <= borrow_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            res_q  <= res_nx;
            bout_q <= borrow_nx;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out    = {done_q, res_ext};
  assign uio_out   = {bout_q, 7'b0};
  assign uio_oe    = 8'b1000_0000;
  assign unused_ok = &{1'b0, ena, ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_serial_subtractor.sv
// Directed bench for the bit-serial subtractor tile.
// Expected values are hand-computed for WIDTH=7.
module tb_tt_um_taghreed_eialsalman_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk;
  int n_err;

  tt_um_taghreed_eialsalman_serial_subtractor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, obs, obs, exp, exp);
    end
  endtask

  // one rising edge, then settle to the falling edge and check constants
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("uio_oe", 32'(uio_oe), 32'h80);
    chk("uio_out_lo", 32'(uio_out[6:0]), 32'd0);
  endtask

  // start pulse with operands, then WIDTH-1 silent shift cycles
  task automatic launch(input logic [6:0] a, input logic [6:0] b);
    ui_in  = {1'b1, a};
    uio_in = {1'b0, b};
    tick();
    ui_in[7] = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [6:0] d,
                           input logic bo);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk({tag, "_busy"}, 32'(uo_out[7]), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(uo_out[7]), 32'd1);
    chk({tag, "_diff"}, 32'(uo_out[6:0]), 32'(d));
    chk({tag, "_bo"}, 32'(uio_out[7]), 32'(bo));
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(negedge clk);
    chk("rst_oe", 32'(uio_oe), 32'h80);
    tick();
    tick();
    chk("rst_uo", 32'(uo_out), 32'd0);
    chk("rst_uio", 32'(uio_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // 100 - 37 = 63
    launch(7'd100, 7'd37);
    finish_op("t1", 7'd63, 1'b0);

    // 5 - 9 wraps to 124, borrow set
    launch(7'd5, 7'd9);
`ifdef SUB_SAT_EN
    finish_op("t2", 7'd0, 1'b1);
`else
    finish_op("t2", 7'd124, 1'b1);
`endif

    // back to back: 127-127 then 0-1
    launch(7'd127, 7'd127);
    finish_op("t3", 7'd0, 1'b0);
    launch(7'd0, 7'd1);
    chk("t4_drop", 32'(uo_out), 32'd0);
    chk("t4_bo_hold", 32'(uio_out[7]), 32'd0);
`ifdef SUB_SAT_EN
    finish_op("t4", 7'd0, 1'b1);
`else
    finish_op("t4", 7'd127, 1'b1);
`endif

    // start held high, operands changed mid-operation
    ui_in  = {1'b1, 7'd20};
    uio_in = {1'b0, 7'd3};
    tick();
    ui_in  = {1'b1, 7'd1};
    uio_in = {1'b0, 7'd100};
    for (int i = 0; i < 7; i++) tick();
    chk("t5_done", 32'(uo_out[7]), 32'd1);
    chk("t5_diff", 32'(uo_out[6:0]), 32'd17);
    chk("t5_bo", 32'(uio_out[7]), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_hold", 32'(uo_out), 32'h80 | 32'd17);
    end
    ui_in[7] = 1'b0;
    tick();
    chk("t5_rel", 32'(uo_out), 32'h80 | 32'd17);

    // reset during the third shift cycle
    launch(7'd50, 7'd10);
    tick();
    tick();
    chk("t6_pre", 32'(uo_out), 32'd17);
    rst_n = 1'b0;
    tick();
    chk("t6_uo", 32'(uo_out), 32'd0);
    chk("t6_uio", 32'(uio_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_nodone", 32'(uo_out), 32'd0);
    end

    // recovers cleanly after the abort
    launch(7'd90, 7'd91);
`ifdef SUB_SAT_EN
    finish_op("t7", 7'd0, 1'b1);
`else
    finish_op("t7", 7'd127, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
